// File: rtl/store_feature_map.sv
// Streams an N x N pixel map from a valid/ready input into memory through a FIFO-buffered DMA write port.
// Optional macro STORE_RELU_EN: the stored value becomes max(pixel, 0) (signed).
module store_feature_map #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int SIZE_WIDTH = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [SIZE_WIDTH-1:0] img_size,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  dma_ready,
    output logic                  dma_enable,
    output logic                  dma_rw,
    output logic [ADDR_WIDTH-1:0] dma_address,
    output logic [DATA_WIDTH-1:0] dma_data,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = 2 * SIZE_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [TW-1:0]         total_q, total_d;
    logic [TW-1:0]         acc_q, acc_d;
    logic [TW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  active, fifo_empty, fifo_full, push, pop;
    logic [DATA_WIDTH-1:0] wdata;

`ifdef STORE_RELU_EN
    assign wdata = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign wdata = in_data;
`endif

    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign fifo_empty = (cnt_q == '0);
    // Full comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign in_ready   = (state_q == S_RUN) && !fifo_full && (acc_q < total_q);
    assign push       = in_valid && in_ready;
    assign pop        = active && !fifo_empty && dma_ready;

    assign dma_enable  = pop;
    assign dma_rw      = 1'b0;
    assign dma_address = active ? base_q + ADDR_WIDTH'(wr_q) : '0;
    assign dma_data    = active ? mem_q[rptr_q] : '0;
    assign busy        = active;
    assign done        = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        total_d = total_q;
        acc_d   = acc_q + TW'(push);
        wr_d    = wr_q + TW'(pop);
        rptr_d  = rptr_q + PW'(pop);
        wptr_d  = wptr_q + PW'(push);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    total_d = TW'(img_size) * TW'(img_size);
                    acc_d   = '0;
                    wr_d    = '0;
                    state_d = (img_size == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   if (acc_d == total_q) state_d = S_DRAIN;
            // Leave on the final pop so done lands the cycle after the last write.
            S_DRAIN: if (wr_d == total_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            total_q <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            total_q <= total_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end
endmodule
